// File: rtl/ibex_pkg.sv
// Shared types for the Ibex writeback stage: instruction class as seen by WB.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

  function automatic logic wb_is_mem(input wb_instr_type_e t);
    return (t == WB_INSTR_LOAD) || (t == WB_INSTR_STORE);
  endfunction

endpackage

// File: rtl/ibex_wb_pipe.sv
// Writeback stage: holds one instruction from ID/EX and writes it to the register file.
//
// state       | meaning
// WB_EMPTY    | no entry held, ready for a new instruction
// WB_HELD     | non-memory entry held, retires this cycle unless flushed
// WB_WAIT_MEM | LOAD/STORE entry held, retires on the LSU response
module ibex_wb_pipe
  import ibex_pkg::*;
#(
  parameter bit DataGating = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_wb_i,
  input  wb_instr_type_e instr_type_i,
  input  logic           rf_we_i,
  input  logic [4:0]     rf_waddr_i,
  input  logic [31:0]    result_ex_i,
  input  logic           ex_valid_i,
  input  logic [31:0]    pc_i,
  input  logic           lsu_resp_valid_i,
  input  logic [31:0]    lsu_rdata_i,
  input  logic           lsu_resp_err_i,
  input  logic           flush_i,
  output logic           ready_wb_o,
  output logic           rf_we_wb_o,
  output logic [4:0]     rf_waddr_wb_o,
  output logic [31:0]    rf_wdata_wb_o,
  output logic           instr_done_wb_o,
  output logic [31:0]    pc_wb_o,
  output logic           load_err_o,
  output logic           outstanding_mem_o
);

  typedef enum logic [1:0] {
    WB_EMPTY    = 2'd0,
    WB_HELD     = 2'd1,
    WB_WAIT_MEM = 2'd2
  } wb_state_e;

  wb_state_e      state_q, state_d;
  wb_instr_type_e type_q, type_d;
  logic           we_q, we_d;
  logic [4:0]     waddr_q, waddr_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    result_q, result_d;

  logic        retire, flush_held, capture, entry_valid, mem_resp;
  logic [31:0] wdata_raw;

  always_comb begin
    mem_resp    = (state_q == WB_WAIT_MEM) && lsu_resp_valid_i;
    retire      = rst_ni && (((state_q == WB_HELD) && !flush_i) || mem_resp);
    // A flushed held entry frees the slot so a same-cycle capture can still land.
    flush_held  = rst_ni && (state_q == WB_HELD) && flush_i;
    ready_wb_o  = !rst_ni || (state_q == WB_EMPTY) || retire || flush_held;
    capture     = en_wb_i && ex_valid_i && ready_wb_o;
    entry_valid = rst_ni && (state_q != WB_EMPTY);

    state_d  = state_q;
    type_d   = type_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    pc_d     = pc_q;
    result_d = result_q;
    if (capture) begin
      state_d  = wb_is_mem(instr_type_i) ? WB_WAIT_MEM : WB_HELD;
      type_d   = instr_type_i;
      we_d     = rf_we_i;
      waddr_d  = rf_waddr_i;
      pc_d     = pc_i;
      result_d = result_ex_i;
    end else if (retire || flush_held) begin
      state_d  = WB_EMPTY;
      type_d   = WB_INSTR_LOAD;
      we_d     = 1'b0;
      waddr_d  = 5'd0;
      pc_d     = 32'd0;
      result_d = 32'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= WB_EMPTY;
      type_q   <= WB_INSTR_LOAD;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      pc_q     <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      pc_q     <= pc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    rf_we_wb_o        = retire && we_q && (type_q != WB_INSTR_STORE) &&
                        !((type_q == WB_INSTR_LOAD) && lsu_resp_err_i);
    wdata_raw         = (type_q == WB_INSTR_LOAD) ? lsu_rdata_i : result_q;
    rf_wdata_wb_o     = (DataGating && !rf_we_wb_o) ? 32'd0 : wdata_raw;
    pc_wb_o           = (DataGating && !entry_valid) ? 32'd0 : pc_q;
    rf_waddr_wb_o     = rst_ni ? waddr_q : 5'd0;
    instr_done_wb_o   = retire;
    load_err_o        = rst_ni && mem_resp && lsu_resp_err_i;
    outstanding_mem_o = rst_ni && (state_q == WB_WAIT_MEM);
  end

endmodule

// File: tb/tb_ibex_wb_pipe.sv
// Bench for ibex_wb_pipe: slot-level reference model compared every cycle plus directed literal checks.
module tb_ibex_wb_pipe;
  import ibex_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           en_wb_i;
  wb_instr_type_e instr_type_i;
  logic           rf_we_i;
  logic [4:0]     rf_waddr_i;
  logic [31:0]    result_ex_i;
  logic           ex_valid_i;
  logic [31:0]    pc_i;
  logic           lsu_resp_valid_i;
  logic [31:0]    lsu_rdata_i;
  logic           lsu_resp_err_i;
  logic           flush_i;
  logic           ready_wb_o;
  logic           rf_we_wb_o;
  logic [4:0]     rf_waddr_wb_o;
  logic [31:0]    rf_wdata_wb_o;
  logic           instr_done_wb_o;
  logic [31:0]    pc_wb_o;
  logic           load_err_o;
  logic           outstanding_mem_o;

  ibex_wb_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i), .instr_type_i(instr_type_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .result_ex_i(result_ex_i),
    .ex_valid_i(ex_valid_i), .pc_i(pc_i), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_rdata_i(lsu_rdata_i), .lsu_resp_err_i(lsu_resp_err_i), .flush_i(flush_i),
    .ready_wb_o(ready_wb_o), .rf_we_wb_o(rf_we_wb_o), .rf_waddr_wb_o(rf_waddr_wb_o),
    .rf_wdata_wb_o(rf_wdata_wb_o), .instr_done_wb_o(instr_done_wb_o), .pc_wb_o(pc_wb_o),
    .load_err_o(load_err_o), .outstanding_mem_o(outstanding_mem_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_stray  = 0;
  bit started  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one optional slot holding the last accepted instruction.
  typedef struct {
    bit             valid;
    wb_instr_type_e kind;
    bit             we;
    logic [4:0]     waddr;
    logic [31:0]    pc;
    logic [31:0]    result;
  } slot_t;

  typedef struct {
    bit          ready, we, done, lerr, outst, freed;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc;
  } exp_t;

  slot_t slot = '{valid: 1'b0, kind: WB_INSTR_LOAD, we: 1'b0, waddr: 5'd0, pc: 32'd0, result: 32'd0};

  function automatic exp_t predict();
    exp_t e;
    bit   is_mem, retire;
    e = '{ready: 1'b1, we: 1'b0, done: 1'b0, lerr: 1'b0, outst: 1'b0, freed: 1'b0,
          waddr: 5'd0, wdata: 32'd0, pc: 32'd0};
    if (!rst_ni) return e;
    if (!slot.valid) return e;
    is_mem  = (slot.kind != WB_INSTR_OTHER);
    retire  = is_mem ? lsu_resp_valid_i : !flush_i;
    e.freed = retire || (!is_mem && flush_i);
    e.ready = e.freed;
    e.done  = retire;
    e.outst = is_mem;
    e.lerr  = is_mem && lsu_resp_valid_i && lsu_resp_err_i;
    e.we    = retire && slot.we && slot.kind != WB_INSTR_STORE &&
              !(slot.kind == WB_INSTR_LOAD && lsu_resp_err_i);
    if (e.we) e.wdata = (slot.kind == WB_INSTR_LOAD) ? lsu_rdata_i : slot.result;
    e.waddr = slot.waddr;
    e.pc    = slot.pc;
    return e;
  endfunction

  always @(posedge clk_i) begin
    exp_t e;
    started <= 1'b1;
    e = predict();
    if (!rst_ni) begin
      slot.valid = 1'b0;
      slot.waddr = 5'd0;
      slot.pc    = 32'd0;
    end else if (en_wb_i && ex_valid_i && e.ready) begin
      slot = '{valid: 1'b1, kind: instr_type_i, we: rf_we_i, waddr: rf_waddr_i,
               pc: pc_i, result: result_ex_i};
    end else if (e.freed) begin
      slot.valid = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (started) begin
      e = predict();
      if (rst_ni && !slot.valid && lsu_resp_valid_i) n_stray++;
      chk("m_ready", 32'(ready_wb_o), 32'(e.ready));
      chk("m_we", 32'(rf_we_wb_o), 32'(e.we));
      chk("m_waddr", 32'(rf_waddr_wb_o), 32'(e.waddr));
      chk("m_wdata", rf_wdata_wb_o, e.wdata);
      chk("m_done", 32'(instr_done_wb_o), 32'(e.done));
      chk("m_pc", pc_wb_o, e.pc);
      chk("m_lerr", 32'(load_err_o), 32'(e.lerr));
      chk("m_outst", 32'(outstanding_mem_o), 32'(e.outst));
    end
  end

  task automatic idle();
    en_wb_i = 0; instr_type_i = WB_INSTR_OTHER; rf_we_i = 0; rf_waddr_i = 0;
    result_ex_i = 0; ex_valid_i = 0; pc_i = 0; lsu_resp_valid_i = 0;
    lsu_rdata_i = 0; lsu_resp_err_i = 0; flush_i = 0;
  endtask

  task automatic issue(input wb_instr_type_e t, input logic we, input logic [4:0] a,
                       input logic [31:0] r, input logic [31:0] pc);
    en_wb_i = 1; ex_valid_i = 1; instr_type_i = t; rf_we_i = we;
    rf_waddr_i = a; result_ex_i = r; pc_i = pc;
  endtask

  task automatic resp(input logic [31:0] d, input logic err);
    lsu_resp_valid_i = 1; lsu_rdata_i = d; lsu_resp_err_i = err;
  endtask

  task automatic to_neg(); @(negedge clk_i); endtask
  task automatic next();   @(posedge clk_i); #1; idle(); endtask

  initial begin
    rst_ni = 0;
    idle();
    repeat (2) next();
    to_neg();
    chk("rst_ready", 32'(ready_wb_o), 32'd1);
    chk("rst_outst", 32'(outstanding_mem_o), 32'd0);
    rst_ni = 1;
    next();

    // OTHER, waddr 5, 0xDEADBEEF
    issue(WB_INSTR_OTHER, 1, 5'd5, 32'hDEADBEEF, 32'h100);
    next();
    to_neg();
    chk("oth_we", 32'(rf_we_wb_o), 32'd1);
    chk("oth_waddr", 32'(rf_waddr_wb_o), 32'd5);
    chk("oth_wdata", rf_wdata_wb_o, 32'hDEADBEEF);
    chk("oth_done", 32'(instr_done_wb_o), 32'd1);
    chk("oth_pc", pc_wb_o, 32'h100);
    next();
    to_neg();
    chk("idle_wdata", rf_wdata_wb_o, 32'd0);

    // en without ex_valid is not a capture
    en_wb_i = 1; instr_type_i = WB_INSTR_OTHER; rf_we_i = 1; rf_waddr_i = 5'd2; result_ex_i = 32'h77;
    next();
    to_neg();
    chk("noexv_done", 32'(instr_done_wb_o), 32'd0);

    // LOAD waddr 7, response after 3 cycles, capture in the same cycle
    issue(WB_INSTR_LOAD, 1, 5'd7, 32'h0, 32'h200);
    next();
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("ld_wait_ready", 32'(ready_wb_o), 32'd0);
      chk("ld_wait_outst", 32'(outstanding_mem_o), 32'd1);
      next();
    end
    resp(32'h12345678, 0);
    issue(WB_INSTR_OTHER, 1, 5'd9, 32'h000000A5, 32'h204);
    to_neg();
    chk("ld_we", 32'(rf_we_wb_o), 32'd1);
    chk("ld_wdata", rf_wdata_wb_o, 32'h12345678);
    chk("ld_waddr", 32'(rf_waddr_wb_o), 32'd7);
    chk("ld_ready", 32'(ready_wb_o), 32'd1);
    next();
    to_neg();
    chk("b2b_waddr", 32'(rf_waddr_wb_o), 32'd9);
    chk("b2b_wdata", rf_wdata_wb_o, 32'h000000A5);
    next();

    // LOAD with bus error
    issue(WB_INSTR_LOAD, 1, 5'd3, 32'h0, 32'h300);
    next();
    resp(32'hFFFF0000, 1);
    to_neg();
    chk("lerr_we", 32'(rf_we_wb_o), 32'd0);
    chk("lerr_err", 32'(load_err_o), 32'd1);
    chk("lerr_done", 32'(instr_done_wb_o), 32'd1);
    chk("lerr_wdata", rf_wdata_wb_o, 32'd0);
    next();

    // STORE never writes
    issue(WB_INSTR_STORE, 1, 5'd12, 32'h0, 32'h400);
    next();
    resp(32'hCAFEF00D, 0);
    to_neg();
    chk("st_we", 32'(rf_we_wb_o), 32'd0);
    chk("st_done", 32'(instr_done_wb_o), 32'd1);
    next();

    // flush of a held OTHER
    issue(WB_INSTR_OTHER, 1, 5'd4, 32'h44, 32'h500);
    next();
    flush_i = 1;
    to_neg();
    chk("fl_we", 32'(rf_we_wb_o), 32'd0);
    chk("fl_done", 32'(instr_done_wb_o), 32'd0);
    next();
    to_neg();
    chk("fl_empty_ready", 32'(ready_wb_o), 32'd1);
    chk("fl_empty_pc", pc_wb_o, 32'd0);

    // flush ignored in WAIT_MEM
    issue(WB_INSTR_LOAD, 1, 5'd6, 32'h0, 32'h600);
    next();
    flush_i = 1;
    to_neg();
    chk("flm_done", 32'(instr_done_wb_o), 32'd0);
    chk("flm_outst", 32'(outstanding_mem_o), 32'd1);
    next();
    resp(32'h00000055, 0);
    to_neg();
    chk("flm_we", 32'(rf_we_wb_o), 32'd1);
    chk("flm_wdata", rf_wdata_wb_o, 32'h55);
    next();

    // flush and capture together: old entry killed, new one taken
    issue(WB_INSTR_OTHER, 1, 5'd10, 32'h111, 32'h700);
    next();
    flush_i = 1;
    issue(WB_INSTR_OTHER, 1, 5'd11, 32'h222, 32'h704);
    to_neg();
    chk("flc_we", 32'(rf_we_wb_o), 32'd0);
    chk("flc_ready", 32'(ready_wb_o), 32'd1);
    next();
    to_neg();
    chk("flc_waddr", 32'(rf_waddr_wb_o), 32'd11);
    chk("flc_wdata", rf_wdata_wb_o, 32'h222);
    next();

    // ten back-to-back OTHER instructions
    for (int i = 0; i < 10; i++) begin
      issue(WB_INSTR_OTHER, 1, 5'(i + 1), 32'h1000 + 32'(i), 32'h800 + 32'(4 * i));
      to_neg();
      if (i > 0) begin
        chk("b2b10_we", 32'(rf_we_wb_o), 32'd1);
        chk("b2b10_wdata", rf_wdata_wb_o, 32'h1000 + 32'(i - 1));
      end
      @(posedge clk_i); #1;
    end
    idle();
    to_neg();
    chk("b2b10_last", rf_wdata_wb_o, 32'h1009);
    next();
    to_neg();
    chk("b2b10_idle_wdata", rf_wdata_wb_o, 32'd0);

    // reset in WAIT_MEM, then a late response
    issue(WB_INSTR_LOAD, 1, 5'd8, 32'h0, 32'h900);
    next();
    rst_ni = 0;
    next();
    rst_ni = 1;
    resp(32'hBADBAD00, 1);
    to_neg();
    chk("rstm_we", 32'(rf_we_wb_o), 32'd0);
    chk("rstm_done", 32'(instr_done_wb_o), 32'd0);
    chk("rstm_lerr", 32'(load_err_o), 32'd0);
    chk("rstm_ready", 32'(ready_wb_o), 32'd1);
    chk("rstm_outst", 32'(outstanding_mem_o), 32'd0);
    next();
    next();

    if (n_stray > 0) $display("note: %0d stray LSU response cycle(s) outside WAIT_MEM", n_stray);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
